// File: rtl/fu_exec_unit.sv
// fu_exec_unit: one ALU functional unit behind a reservation-station issue lane.
// Executes 1-cycle ALU ops or a MUL_LAT-cycle MUL, then holds the result until granted.
module fu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 6,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_is_ls,
    input  logic             issue_alusrc,
    input  logic [3:0]       issue_alu_type,
    input  logic [TAG_W-1:0] issue_rd_tag,
    input  logic [TAG_W-1:0] issue_rob_num,
    input  logic [XLEN-1:0]  issue_rs1_val,
    input  logic [XLEN-1:0]  issue_rs2_val,
    input  logic [XLEN-1:0]  issue_imm,
    output logic             fu_ready,
    output logic             wb_valid,
    input  logic             wb_grant,
    output logic [TAG_W-1:0] wb_tag,
    output logic [XLEN-1:0]  wb_val,
    output logic [TAG_W-1:0] wb_rob_num,
    output logic             wb_is_ls,
    output logic [XLEN-1:0]  wb_st_data,
    output logic             issue_err
);

    localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [3:0] OP_MUL = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] rob_q, rob_d;
    logic [XLEN-1:0]  val_q, val_d;
    logic [XLEN-1:0]  st_q, st_d;
    logic             ls_q, ls_d;
    logic             err_q, err_d;

    logic [XLEN-1:0]  op_b;
    logic [4:0]       sh;
    logic [XLEN-1:0]  res;

    // Result datapath, evaluated on the issue inputs and captured at accept.
    // The product is registered at issue; the BUSY countdown models the multiplier latency.
    always_comb begin
        op_b = issue_alusrc ? issue_imm : issue_rs2_val;
        sh   = op_b[4:0];
        res  = '0;
        if (issue_is_ls) begin
            res = issue_rs1_val + issue_imm;
        end else begin
            case (issue_alu_type)
                4'd1:    res = issue_rs1_val + op_b;
                4'd2:    res = issue_rs1_val - op_b;
                4'd3:    res = issue_rs1_val & op_b;
                4'd4:    res = issue_rs1_val | op_b;
                4'd5:    res = issue_rs1_val ^ op_b;
                4'd6:    res = issue_rs1_val << sh;
                4'd7:    res = issue_rs1_val >> sh;
                4'd8:    res = $signed(issue_rs1_val) >>> sh;
                4'd9:    res = {{(XLEN-1){1'b0}}, $signed(issue_rs1_val) < $signed(op_b)};
                4'd10:   res = {{(XLEN-1){1'b0}}, issue_rs1_val < op_b};
                4'd11:   res = issue_imm;
                4'd12:   res = issue_rs1_val * op_b;
                default: res = '0;
            endcase
        end
    end

    // Next-state logic: accept in IDLE, count MUL latency in BUSY, hold in DONE until grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        rob_d   = rob_q;
        val_d   = val_q;
        st_d    = st_q;
        ls_d    = ls_q;
        err_d   = err_q;
        if (issue_valid && (state_q != S_IDLE || issue_alu_type == 4'd0)) begin
            err_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (issue_valid && issue_alu_type != 4'd0) begin
                    tag_d   = issue_rd_tag;
                    rob_d   = issue_rob_num;
                    val_d   = res;
                    st_d    = issue_rs2_val;
                    ls_d    = issue_is_ls;
                    cnt_d   = '0;
                    if (!issue_is_ls && issue_alu_type == OP_MUL) begin
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (wb_grant) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            rob_q   <= '0;
            val_q   <= '0;
            st_q    <= '0;
            ls_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            rob_q   <= rob_d;
            val_q   <= val_d;
            st_q    <= st_d;
            ls_q    <= ls_d;
            err_q   <= err_d;
        end
    end

    assign fu_ready   = (state_q == S_IDLE);
    assign wb_valid   = (state_q == S_DONE);
    assign wb_tag     = tag_q;
    assign wb_val     = val_q;
    assign wb_rob_num = rob_q;
    assign wb_is_ls   = ls_q;
    assign wb_st_data = st_q;
    assign issue_err  = err_q;

endmodule

// File: tb/tb_fu_exec_unit.sv
// tb_fu_exec_unit: directed vectors with a scoreboard queue; a monitor
// pops and compares each result on the cycle it is granted.
module tb_fu_exec_unit;

    localparam int XLEN    = 32;
    localparam int TAG_W   = 6;
    localparam int MUL_LAT = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid;
    logic             issue_is_ls;
    logic             issue_alusrc;
    logic [3:0]       issue_alu_type;
    logic [TAG_W-1:0] issue_rd_tag;
    logic [TAG_W-1:0] issue_rob_num;
    logic [XLEN-1:0]  issue_rs1_val;
    logic [XLEN-1:0]  issue_rs2_val;
    logic [XLEN-1:0]  issue_imm;
    logic             fu_ready;
    logic             wb_valid;
    logic             wb_grant;
    logic [TAG_W-1:0] wb_tag;
    logic [XLEN-1:0]  wb_val;
    logic [TAG_W-1:0] wb_rob_num;
    logic             wb_is_ls;
    logic [XLEN-1:0]  wb_st_data;
    logic             issue_err;

    fu_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_is_ls(issue_is_ls),
        .issue_alusrc(issue_alusrc), .issue_alu_type(issue_alu_type),
        .issue_rd_tag(issue_rd_tag), .issue_rob_num(issue_rob_num),
        .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
        .issue_imm(issue_imm), .fu_ready(fu_ready), .wb_valid(wb_valid),
        .wb_grant(wb_grant), .wb_tag(wb_tag), .wb_val(wb_val),
        .wb_rob_num(wb_rob_num), .wb_is_ls(wb_is_ls),
        .wb_st_data(wb_st_data), .issue_err(issue_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [TAG_W-1:0] rob;
        logic [XLEN-1:0]  val;
        logic             is_ls;
        logic [XLEN-1:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a granted result must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid && wb_grant) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_val", 64'(wb_val), 64'(e.val));
                    chk("wb_tag", 64'(wb_tag), 64'(e.tag));
                    chk("wb_rob", 64'(wb_rob_num), 64'(e.rob));
                    chk("wb_is_ls", 64'(wb_is_ls), 64'(e.is_ls));
                    chk("wb_st_data", 64'(wb_st_data), 64'(e.st));
                end
            end
        end
    end

    task automatic drive_issue(input logic ls, input logic src, input logic [3:0] typ,
                               input logic [TAG_W-1:0] tag, input logic [TAG_W-1:0] rob,
                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [XLEN-1:0] imm);
        @(posedge clk);
        #1;
        issue_valid    = 1'b1;
        issue_is_ls    = ls;
        issue_alusrc   = src;
        issue_alu_type = typ;
        issue_rd_tag   = tag;
        issue_rob_num  = rob;
        issue_rs1_val  = a;
        issue_rs2_val  = b;
        issue_imm      = imm;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    // Returns number of negedges after the issue edge until wb_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (wb_valid) begin
                lat = i;
                break;
            end
            chk("fu_ready_while_busy", 64'(fu_ready), 64'd0);
        end
        if (lat == 0) chk("wb_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic grant_and_check;
        @(posedge clk);
        #1;
        wb_grant = 1'b1;
        @(posedge clk);
        #1;
        wb_grant = 1'b0;
        @(negedge clk);
        chk("wb_valid_after_grant", 64'(wb_valid), 64'd0);
        chk("fu_ready_after_grant", 64'(fu_ready), 64'd1);
    endtask

    task automatic do_op(input string name, input logic ls, input logic src,
                         input logic [3:0] typ, input logic [TAG_W-1:0] tag,
                         input logic [TAG_W-1:0] rob, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm,
                         input logic [XLEN-1:0] expv, input int exp_lat);
        int lat;
        exp_t e;
        e.tag = tag; e.rob = rob; e.val = expv; e.is_ls = ls; e.st = b;
        exp_q.push_back(e);
        drive_issue(ls, src, typ, tag, rob, a, b, imm);
        wait_valid(lat);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        grant_and_check();
    endtask

    initial begin
        int lat;
        logic [XLEN-1:0] held_val;
        logic            no_wb;
        reset = 1'b1; issue_valid = 1'b0; issue_is_ls = 1'b0; issue_alusrc = 1'b0;
        issue_alu_type = 4'd0; issue_rd_tag = '0; issue_rob_num = '0;
        issue_rs1_val = '0; issue_rs2_val = '0; issue_imm = '0; wb_grant = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_fu_ready", 64'(fu_ready), 64'd1);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_issue_err", 64'(issue_err), 64'd0);
        chk("rst_wb_val", 64'(wb_val), 64'd0);
        chk("rst_wb_tag", 64'(wb_tag), 64'd0);

        // ALU results appear one cycle after issue; MUL after MUL_LAT+1 negedges here.
        do_op("add",  0, 0, 4'd1,  6'd9, 6'd3, 32'd5, 32'd7, 32'd0, 32'd12, 1);
        do_op("sub",  0, 0, 4'd2,  6'd1, 6'd4, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 1);
        do_op("sra",  0, 1, 4'd8,  6'd2, 6'd5, 32'h8000_0000, 32'h123, 32'd4, 32'hF800_0000, 1);
        do_op("sltu", 0, 0, 4'd10, 6'd3, 6'd6, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1, 1);
        do_op("slt",  0, 0, 4'd9,  6'd4, 6'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1);
        do_op("lui",  0, 1, 4'd11, 6'd5, 6'd8, 32'd99, 32'd0, 32'h1234_5000, 32'h1234_5000, 1);
        do_op("srl",  0, 1, 4'd7,  6'd6, 6'd9, 32'h8000_0000, 32'd0, 32'd4, 32'h0800_0000, 1);
        do_op("op13", 0, 0, 4'd13, 6'd7, 6'd10, 32'd5, 32'd6, 32'd0, 32'd0, 1);
        do_op("mul0", 0, 0, 4'd12, 6'd8, 6'd11, 32'h10000, 32'h10000, 32'd0, 32'd0, MUL_LAT + 1);
        do_op("mul42", 0, 1, 4'd12, 6'd10, 6'd12, 32'd6, 32'd0, 32'd7, 32'd42, MUL_LAT + 1);
        do_op("ls",   1, 0, 4'd1,  6'd11, 6'd13, 32'h1000, 32'hAB, 32'hFFFF_FFFC, 32'hFFC, 1);
        chk("err_clean", 64'(issue_err), 64'd0);

        // Hold result without grant; an extra issue must be dropped and flagged.
        begin
            exp_t e;
            e.tag = 6'd20; e.rob = 6'd21; e.val = 32'd15; e.is_ls = 1'b0; e.st = 32'd5;
            exp_q.push_back(e);
        end
        drive_issue(0, 0, 4'd12, 6'd20, 6'd21, 32'd3, 32'd5, 32'd0);
        wait_valid(lat);
        held_val = wb_val;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                @(posedge clk);
                #1;
                issue_valid = 1'b1; issue_is_ls = 1'b0; issue_alu_type = 4'd1;
                issue_rd_tag = 6'd33; issue_rs1_val = 32'd1; issue_rs2_val = 32'd1;
                @(posedge clk);
                #1;
                issue_valid = 1'b0;
            end else begin
                @(posedge clk);
            end
            @(negedge clk);
            chk("hold_valid", 64'(wb_valid), 64'd1);
            chk("hold_val", 64'(wb_val), 64'd15);
            chk("hold_tag", 64'(wb_tag), 64'd20);
        end
        chk("hold_val_first", 64'(held_val), 64'd15);
        chk("busy_issue_err", 64'(issue_err), 64'd1);
        grant_and_check();

        // Reset in the middle of a MUL discards it and clears the sticky error.
        drive_issue(0, 0, 4'd12, 6'd30, 6'd31, 32'd2, 32'd2, 32'd0);
        @(negedge clk);
        chk("mul_busy", 64'(fu_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(fu_ready), 64'd1);
        chk("post_rst_err", 64'(issue_err), 64'd0);
        no_wb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb_valid) no_wb = 1'b0;
        end
        chk("no_wb_after_rst", 64'(no_wb), 64'd1);

        // alu_type 0 is dropped, flagged, and leaves the unit idle.
        drive_issue(0, 0, 4'd0, 6'd1, 6'd1, 32'd1, 32'd1, 32'd0);
        @(negedge clk);
        chk("type0_err", 64'(issue_err), 64'd1);
        chk("type0_ready", 64'(fu_ready), 64'd1);
        chk("type0_no_wb", 64'(wb_valid), 64'd0);

        // A grant while idle is ignored.
        @(posedge clk);
        #1;
        wb_grant = 1'b1;
        @(posedge clk);
        #1;
        wb_grant = 1'b0;
        @(negedge clk);
        chk("idle_grant_ready", 64'(fu_ready), 64'd1);
        chk("idle_grant_valid", 64'(wb_valid), 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
